fifo_wr_ctrl: RTL and testbench

Write-side controller for the async FIFO, and the parametrised successor to the fixed-width write-pointer block. It runs entirely in the write clock domain. It takes the read pointer (Gray) from the read domain, synchronises it internally, and produces the Gray write pointer for the read side, the memory write address, a registered full flag, an occupancy estimate, an almost-full flag and a sticky overflow error.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_ptr_sync.sv | 37 +++
 rtl/fifo_wr_ctrl.sv | 99 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer types and Gray/binary conversion helpers for
//               the async FIFO write and read controllers.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend into ptr_word_t
    // and cast the result back down to their own pointer width.
    localparam int c_MAX_PTR_W = 32;

    typedef logic [c_MAX_PTR_W-1:0] ptr_word_t;

    function automatic ptr_word_t b2g(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs convert correctly: the upper zeros stay zero.
    function automatic ptr_word_t g2b(input ptr_word_t gray);
        ptr_word_t bin;
        bin = '0;
        bin[c_MAX_PTR_W-1] = gray[c_MAX_PTR_W-1];
        for (int i = c_MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_sync
// Description : Multi-stage flop chain bringing a Gray pointer into the local
//               clock domain; shared by the write and read controllers.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fifo_ptr_sync #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule : fifo_ptr_sync
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Async FIFO write-side controller: write pointer, memory
//               address, full / almost-full / occupancy and sticky overflow.
// Revision    : 1.0 - parametrised successor to the fixed-width wptr block
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AW           = $clog2(DEPTH),
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic          wren,
    input  logic          ovf_clr,
    input  logic [AW:0]   rptr_gray,
    output logic          wr_accept,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wrptr_gray,
    output logic          wr_full,
    output logic          wr_almost_full,
    output logic [AW:0]   wr_count,
    output logic          wr_overflow
);

    localparam int             PTR_W          = AW + 1;
    localparam logic [PTR_W-1:0] c_AFULL_THRESH = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wgray;
    logic [AW-1:0]    r_waddr;
    logic             r_full;
    logic             r_afull;
    logic [PTR_W-1:0] r_count;
    logic             r_ovf;

    logic             w_push;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_wgray_next;
    logic [PTR_W-1:0] w_rq;
    logic [PTR_W-1:0] w_rq_bin;
    logic [PTR_W-1:0] w_full_gray;
    logic [PTR_W-1:0] w_count_next;

    fifo_ptr_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d   (rptr_gray),
        .q   (w_rq)
    );

    assign w_push       = wren & ~r_full;
    assign w_wbin_next  = r_wbin + PTR_W'(w_push);
    assign w_wgray_next = PTR_W'(b2g(ptr_word_t'(w_wbin_next)));
    assign w_rq_bin     = PTR_W'(g2b(ptr_word_t'(w_rq)));

    // Full in Gray space: read pointer one lap behind has its top two bits inverted.
    assign w_full_gray  = {~w_rq[AW:AW-1], w_rq[AW-2:0]};
    assign w_count_next = w_wbin_next - w_rq_bin;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_waddr <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_waddr <= w_wbin_next[AW-1:0];
            r_full  <= (w_wgray_next == w_full_gray);
            r_afull <= (w_count_next >= c_AFULL_THRESH);
            r_count <= w_count_next;
            // A rejected write in the same cycle as a clear keeps the flag set.
            r_ovf   <= (wren & r_full) | (r_ovf & ~ovf_clr);
        end
    end

    assign wr_accept      = w_push;
    assign waddr          = r_waddr;
    assign wrptr_gray     = r_wgray;
    assign wr_full        = r_full;
    assign wr_almost_full = r_afull;
    assign wr_count       = r_count;
    assign wr_overflow    = r_ovf;

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Directed self-checking bench for fifo_wr_ctrl at DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    localparam int AW = 4;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          wren;
    logic          ovf_clr;
    logic [AW:0]   rptr_gray;
    logic          wr_accept;
    logic [AW-1:0] waddr;
    logic [AW:0]   wrptr_gray;
    logic          wr_full;
    logic          wr_almost_full;
    logic [AW:0]   wr_count;
    logic          wr_overflow;

    int checks = 0;
    int errors = 0;

    fifo_wr_ctrl #(
        .DEPTH        (16),
        .AW           (AW),
        .AFULL_THRESH (14),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk           (wclk),
        .wrst           (wrst),
        .wren           (wren),
        .ovf_clr        (ovf_clr),
        .rptr_gray      (rptr_gray),
        .wr_accept      (wr_accept),
        .waddr          (waddr),
        .wrptr_gray     (wrptr_gray),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_count       (wr_count),
        .wr_overflow    (wr_overflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] tb_b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        wrst = 1'b1; wren = 1'b1; ovf_clr = 1'b0; rptr_gray = '0;
        repeat (3) @(posedge wclk);
        #1;
        checks++;
        if ({wrptr_gray, waddr, wr_full, wr_count, wr_overflow, wr_almost_full} !== '0) begin
            errors++;
            $display("FAIL reset_held: gray=%b waddr=%0d full=%b count=%0d ovf=%b afull=%b required all 0",
                     wrptr_gray, waddr, wr_full, wr_count, wr_overflow, wr_almost_full);
        end
        wrst = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        checks++;
        if (waddr !== 4'd3 || wr_count !== 5'd3) begin
            errors++;
            $display("FAIL reset_prewrite: waddr=%0d count=%0d required 3 3", waddr, wr_count);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2 wrst = 1'b1;
        #1;
        checks++;
        if ({wrptr_gray, waddr, wr_full, wr_count, wr_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_async: gray=%b waddr=%0d count=%0d required 0 0 0",
                     wrptr_gray, waddr, wr_count);
        end
        @(posedge wclk);
        #1;
        wren = 1'b0; wrst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1;
            #1;
            checks++;
            if (waddr !== 4'(i) || wr_accept !== 1'b1) begin
                errors++;
                $display("FAIL fill_addr[%0d]: waddr=%0d accept=%b required %0d 1", i, waddr, wr_accept, i);
            end
            @(posedge wclk);
            #1;
            checks++;
            if (wr_count !== 5'(i + 1) || wr_full !== (i == 15) || wr_almost_full !== (i + 1 >= 14)) begin
                errors++;
                $display("FAIL fill_flags[%0d]: count=%0d full=%b afull=%b required %0d %b %b",
                         i, wr_count, wr_full, wr_almost_full, i + 1, (i == 15), (i + 1 >= 14));
            end
        end
        wren = 1'b0;
        checks++;
        if (waddr !== 4'd0 || wrptr_gray !== 5'b11000 || wr_count !== 5'd16) begin
            errors++;
            $display("FAIL fill_end: waddr=%0d gray=%b count=%0d required 0 11000 16", waddr, wrptr_gray, wr_count);
        end
    endtask

    task automatic test_overflow();
        wren = 1'b1;
        #1;
        checks++;
        if (wr_accept !== 1'b0) begin
            errors++;
            $display("FAIL ovf_accept: accept=%b required 0", wr_accept);
        end
        @(posedge wclk);
        #1;
        wren = 1'b0;
        checks++;
        if (wr_overflow !== 1'b1 || wrptr_gray !== 5'b11000 || waddr !== 4'd0 || wr_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b gray=%b waddr=%0d count=%0d required 1 11000 0 16",
                     wr_overflow, wrptr_gray, waddr, wr_count);
        end
        ovf_clr = 1'b1;
        @(posedge wclk);
        #1;
        checks++;
        if (wr_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b required 0", wr_overflow);
        end
        wren = 1'b1;
        @(posedge wclk);
        #1;
        checks++;
        if (wr_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b required 1", wr_overflow);
        end
        wren = 1'b0;
        @(posedge wclk);
        #1;
        ovf_clr = 1'b0;
    endtask

    task automatic test_release();
        rptr_gray = 5'b00110;
        repeat (2) @(posedge wclk);
        #1;
        checks++;
        if (wr_full !== 1'b1 || wr_count !== 5'd16) begin
            errors++;
            $display("FAIL release_early: full=%b count=%0d required 1 16", wr_full, wr_count);
        end
        @(posedge wclk);
        #1;
        checks++;
        if (wr_full !== 1'b0 || wr_count !== 5'd12 || wr_almost_full !== 1'b0) begin
            errors++;
            $display("FAIL release: full=%b count=%0d afull=%b required 0 12 0", wr_full, wr_count, wr_almost_full);
        end
    endtask

    task automatic test_almost_full();
        rptr_gray = '0;
        wrst = 1'b1;
        #1 wrst = 1'b0;
        wren = 1'b1;
        repeat (13) @(posedge wclk);
        #1;
        checks++;
        if (wr_almost_full !== 1'b0 || wr_count !== 5'd13) begin
            errors++;
            $display("FAIL afull_13: afull=%b count=%0d required 0 13", wr_almost_full, wr_count);
        end
        @(posedge wclk);
        #1;
        wren = 1'b0;
        checks++;
        if (wr_almost_full !== 1'b1 || wr_count !== 5'd14 || wr_full !== 1'b0) begin
            errors++;
            $display("FAIL afull_14: afull=%b count=%0d full=%b required 1 14 0", wr_almost_full, wr_count, wr_full);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] n;
        logic [4:0] prev;
        rptr_gray = '0;
        wrst = 1'b1;
        #1 wrst = 1'b0;
        n = '0;
        prev = wrptr_gray;
        for (int k = 0; k < 100; k++) begin
            rptr_gray = (k >= 4) ? tb_b2g(n - 5'd4) : 5'd0;
            wren = 1'b1;
            #1;
            checks++;
            if (wr_accept !== 1'b1) begin
                errors++;
                $display("FAIL wrap_accept[%0d]: accept=%b required 1", k, wr_accept);
            end
            @(posedge wclk);
            #1;
            n = n + 5'd1;
            checks++;
            if (wrptr_gray !== tb_b2g(n) || $countones(prev ^ wrptr_gray) != 1) begin
                errors++;
                $display("FAIL wrap_gray[%0d]: gray=%b prev=%b required %b", k, wrptr_gray, prev, tb_b2g(n));
            end
            checks++;
            if (wr_full !== 1'b0 || wr_count > 5'd7) begin
                errors++;
                $display("FAIL wrap_count[%0d]: full=%b count=%0d required 0 <=7", k, wr_full, wr_count);
            end
            prev = wrptr_gray;
        end
        wren = 1'b0;
        checks++;
        if (waddr !== 4'd4) begin
            errors++;
            $display("FAIL wrap_end: waddr=%0d required 4", waddr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_almost_full();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire
